fwd_bypass_unit: RTL

//  Parametrised operand bypass/hazard unit for the 5-stage pipeline; supersedes fixed E-stage forwarding muxes.

---
 rtl/fwd_bypass_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/fwd_bypass_unit.sv
// Operand bypass and hazard unit: tracks in-flight producers, forwards the
// youngest ready result to E-stage operands and stalls D on Tuse/Tnew conflicts.
module fwd_bypass_unit #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int DEPTH = 4,
  parameter int TW    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_wa,
  input  logic [TW-1:0]        id_tnew,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC*TW-1:0]   id_tuse,
  input  logic [NSRC*DW-1:0]   rf_data_e,
  input  logic [DEPTH*DW-1:0]  stg_data,
  output logic                 stall,
  output logic [NSRC*DW-1:0]   fwd_data,
  output logic [NSRC*3-1:0]    fwd_sel,
  output logic                 fwd_err,
  output logic [15:0]          stall_cnt
);

  logic [DEPTH-1:0]   r_vld;
  logic [AW-1:0]      r_wa   [DEPTH];
  logic [TW-1:0]      r_tnew [DEPTH];
  logic [NSRC*AW-1:0] r_esrc;
  logic [15:0]        r_stall_cnt;

  logic [TW-1:0]      w_tdec [DEPTH];
  logic [NSRC-1:0]    w_ferr;
  logic [NSRC-1:0]    w_sreq;
  logic               w_unused;

  // Slot 0 result bus is never a forwarding source.
  assign w_unused = ^stg_data[DW-1:0];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      w_tdec[k] = (r_tnew[k] == '0) ? '0 : r_tnew[k] - 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest hit overrides.
  always_comb begin
    fwd_data = rf_data_e;
    fwd_sel  = '1;
    w_ferr   = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        if (r_vld[k] && r_wa[k] != '0 &&
            r_wa[k] == r_esrc[i*AW +: AW]) begin
          fwd_data[i*DW +: DW] = stg_data[k*DW +: DW];
          fwd_sel[i*3 +: 3]    = 3'(k);
          w_ferr[i]            = (r_tnew[k] != '0);
        end
      end
    end
    fwd_err = |w_ferr;
  end

  always_comb begin
    w_sreq = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = DEPTH-2; k >= 0; k--) begin
        if (id_valid && r_vld[k] && r_wa[k] != '0 &&
            r_wa[k] == id_src[i*AW +: AW]) begin
          w_sreq[i] = (r_tnew[k] > id_tuse[i*TW +: TW]);
        end
      end
    end
    stall = |w_sreq;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld       <= '0;
      r_esrc      <= '0;
      r_stall_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_wa[k]   <= '0;
        r_tnew[k] <= '0;
      end
    end else if (flush) begin
      r_vld  <= '0;
      r_esrc <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_wa[k]   <= '0;
        r_tnew[k] <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_wa[k]   <= r_wa[k-1];
        r_tnew[k] <= w_tdec[k-1];
      end
      if (stall) begin
        r_vld[0]  <= 1'b0;
        r_wa[0]   <= '0;
        r_tnew[0] <= '0;
        r_esrc    <= '0;
      end else begin
        r_vld[0]  <= id_valid;
        r_wa[0]   <= id_wa;
        r_tnew[0] <= id_tnew;
        r_esrc    <= id_src;
      end
      if (stall && r_stall_cnt != 16'hFFFF) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
